mac_frame_accumulator: RTL

MAC_FRAME_ACCUMULATOR -- requirements
Module: mac_frame_accumulator

---
 rtl/mac_frame_accumulator.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mac_frame_accumulator.sv
// rtl/mac_frame_accumulator.sv - frame multiply-accumulate with two-stage pipeline and result handshake
//
// Accepts LEN unsigned 4x4 operand pairs, multiplies them (stage 1), and
// sums the products into an ACC_W-bit accumulator (stage 2). The result
// is then held for a valid/ready handshake.
//
// Parameters:
//   ACC_W  accumulator / result width (8..32)
//   LEN    samples per frame (1..255)
//
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   clr        synchronous frame abort, highest priority
//   in_valid   operand pair offered
//   in_ready   operand pair accepted when high together with in_valid
//   in_a/in_b  unsigned 4-bit operands
//   out_valid  frame result available
//   out_ready  consumer takes result
//   out_sum    accumulated sum of LEN products
//   out_ovf    an addition in this frame carried out of ACC_W bits
//
// Build option: define MAC_SATURATE_EN to clamp the accumulator at
// 2^ACC_W-1 on overflow; otherwise it wraps modulo 2^ACC_W.

module mac_frame_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_a,
  input  logic [3:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_ovf
);

  typedef enum logic [1:0] {ACCUM, DRAIN, DONE} state_t;

  state_t           state, state_next;
  logic             in_en;        // holds in_ready low until the first edge after reset
  logic [7:0]       cnt;
  logic             s1_valid;
  logic             s1_last;
  logic [7:0]       s1_prod;
  logic             s2_last;      // last product of the frame has just been accumulated
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_next;
  logic             accept;
  logic             last_sample;

  assign accept      = in_valid && in_ready;
  assign last_sample = (cnt == 8'(LEN - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = in_en;
        if (in_en && in_valid && last_sample) state_next = DRAIN;
      end
      DRAIN: begin
        if (s2_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
    if (clr) state_next = ACCUM;
  end

  // Stage 2 adder: one spare bit captures the carry out of ACC_W.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W-7){1'b0}}, s1_prod};
    carry   = sum_ext[ACC_W];
`ifdef MAC_SATURATE_EN
    // Once the frame has overflowed the accumulator stays pinned at full scale.
    acc_next = (carry || ovf) ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
`else
    acc_next = sum_ext[ACC_W-1:0];
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_en    <= 1'b0;
      cnt      <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s2_last  <= 1'b0;
      acc      <= '0;
      ovf      <= 1'b0;
    end else begin
      in_en <= 1'b1;
      if (clr) begin
        cnt      <= '0;
        s1_valid <= 1'b0;
        s1_last  <= 1'b0;
        s2_last  <= 1'b0;
        acc      <= '0;
        ovf      <= 1'b0;
      end else begin
        s1_valid <= accept;
        s1_last  <= accept && last_sample;
        if (accept) begin
          s1_prod <= {4'b0, in_a} * {4'b0, in_b};
          cnt     <= last_sample ? 8'd0 : cnt + 8'd1;
        end
        s2_last <= s1_valid && s1_last;
        if (out_valid && out_ready) begin
          acc <= '0;
          ovf <= 1'b0;
        end else if (s1_valid) begin
          acc <= acc_next;
          ovf <= ovf || carry;
        end
      end
    end
  end

  assign out_sum = acc;
  assign out_ovf = ovf;

endmodule
